// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit, iterative shift-add / restoring divide with single-cycle fast path
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             kill_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [2:0]         op;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod, prod_next, prod_signed;
    logic [CW-1:0]      cnt;
    logic               neg_p, neg_r;

    logic               accept, signed_a, signed_b, sa, sb, is_div, div0, ovf, fast;
    logic [WIDTH-1:0]   a_mag, b_mag, fast_res, calc_res, quot, rem, diff;
    logic [2*WIDTH-1:0] fast_prod, fast_signed;
    logic [WIDTH:0]     mul_sum, shifted;
    logic               ge;

    assign accept   = valid_i & ready_o & ~kill_i;
    assign signed_a = (funct3_i == 3'b001) | (funct3_i == 3'b010) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign signed_b = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign sa       = signed_a & a_i[WIDTH-1];
    assign sb       = signed_b & b_i[WIDTH-1];
    assign a_mag    = sa ? -a_i : a_i;
    assign b_mag    = sb ? -b_i : b_i;
    assign is_div   = funct3_i[2];
    assign div0     = is_div & (b_i == '0);
    assign ovf      = is_div & ~funct3_i[0] & (a_i == MIN) & (b_i == '1);
    assign fast     = div0 | ovf | (FAST_MUL & ~is_div);

    assign fast_prod   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    assign fast_signed = (sa ^ sb) ? -fast_prod : fast_prod;
    assign fast_res    = div0 ? (funct3_i[1] ? a_i : '1) :
                         ovf  ? (funct3_i[1] ? '0 : a_i) :
                         (funct3_i[1:0] == 2'b00 ? fast_signed[WIDTH-1:0] : fast_signed[2*WIDTH-1:WIDTH]);

    // prod holds {hi, multiplier} for multiply and {remainder, dividend} for divide
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign shifted   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign ge        = shifted >= {1'b0, opnd};
    assign diff      = shifted[WIDTH-1:0] - opnd;
    assign prod_next = op[2] ? {ge ? diff : shifted[WIDTH-1:0], prod[WIDTH-2:0], ge}
                             : {mul_sum, prod[WIDTH-1:1]};
    assign prod_signed = neg_p ? -prod_next : prod_next;
    assign quot        = prod_next[WIDTH-1:0];
    assign rem         = prod_next[2*WIDTH-1:WIDTH];
    assign calc_res    = op[2] ? (op[1] ? (neg_r ? -rem : rem) : (neg_p ? -quot : quot))
                               : (op[1:0] == 2'b00 ? prod_signed[WIDTH-1:0] : prod_signed[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (kill_i)                            state_next = IDLE;
        else if (state == IDLE && accept)      state_next = fast ? DONE : CALC;
        else if (state == CALC && cnt == LAST) state_next = DONE;
        else if (state == DONE)                state_next = IDLE;
    end

    always_comb begin
        ready_o = state == IDLE;
        busy_o  = state != IDLE;
        done_o  = (state == DONE) & ~kill_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op       <= '0;
            opnd     <= '0;
            prod     <= '0;
            cnt      <= '0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else if (accept) begin
            op    <= funct3_i;
            opnd  <= is_div ? b_mag : a_mag;
            prod  <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            cnt   <= '0;
            neg_p <= sa ^ sb;
            neg_r <= sa;
            if (fast) result_o <= fast_res;
        end else if (state == CALC && !kill_i) begin
            prod <= prod_next;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) result_o <= calc_res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit, iterative and FAST_MUL instances
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, valid_f = 1'b0, kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0, b = '0;
    logic        ready, busy, done, ready_f, busy_f, done_f;
    logic [31:0] result, result_f;

    typedef struct {logic [31:0] res; int acc; int lat;} exp_t;
    exp_t q[$], qf[$];
    exp_t e_m, e_f;
    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [31:0] last = '0;

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .funct3_i(funct3), .a_i(a), .b_i(b),
        .kill_i(kill), .ready_o(ready), .busy_o(busy), .done_o(done), .result_o(result));

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_f), .funct3_i(funct3), .a_i(a), .b_i(b),
        .kill_i(kill), .ready_o(ready_f), .busy_o(busy_f), .done_o(done_f), .result_o(result_f));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_n && done) begin
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done result=%h", result);
        end else begin
            e_m = q.pop_front();
            if (result !== e_m.res) begin n_fail++; $display("FAIL result got %h expected %h", result, e_m.res); end
            n_tests++;
            if (cyc - e_m.acc + 1 !== e_m.lat) begin n_fail++; $display("FAIL latency got %0d expected %0d", cyc - e_m.acc + 1, e_m.lat); end
        end
    end

    always @(negedge clk) if (rst_n && done_f) begin
        n_tests++;
        if (qf.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done_fast result=%h", result_f);
        end else begin
            e_f = qf.pop_front();
            if (result_f !== e_f.res) begin n_fail++; $display("FAIL fast_result got %h expected %h", result_f, e_f.res); end
            n_tests++;
            if (cyc - e_f.acc + 1 !== e_f.lat) begin n_fail++; $display("FAIL fast_latency got %0d expected %0d", cyc - e_f.acc + 1, e_f.lat); end
        end
    end

    task automatic send(input bit f, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat);
        int n = 0;
        @(negedge clk);
        while (!(f ? ready_f : ready) && n < 100) begin @(negedge clk); n++; end
        n_tests++;
        if (!(f ? ready_f : ready)) begin n_fail++; $display("FAIL send_ready got 0 expected 1"); end
        funct3 = op; a = x; b = y;
        if (f) valid_f = 1'b1; else valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; valid_f = 1'b0;
        if (f) qf.push_back('{exp, cyc, lat}); else q.push_back('{exp, cyc, lat});
        last = exp;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || qf.size() != 0) && n < 200) begin @(negedge clk); n++; end
        n_tests++;
        if (q.size() != 0 || qf.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending got %0d expected 0", q.size() + qf.size());
            q.delete(); qf.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_tests += 4;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b expected 1", ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h expected 0", result); end
    endtask

    task automatic test_mul_latency();
        int bad = 0;
        send(0, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && ready === 1'b0 && done === 1'b0)) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL mul_calc_flags got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        n_tests++;
        if (!(done === 1'b1 && busy === 1'b1 && ready === 1'b0)) begin
            n_fail++; $display("FAIL mul_done_flags got d%b b%b r%b expected d1 b1 r0", done, busy, ready);
        end
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_after got %b expected 1", ready); end
        drain();
    endtask

    task automatic test_mulh();
        for (int f = 0; f < 2; f++) begin
            send(f[0], 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, f ? 1 : 33);
            drain();
            send(f[0], 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, f ? 1 : 33);
            drain();
            send(f[0], 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, f ? 1 : 33);
            drain();
            send(f[0], 3'b000, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, f ? 1 : 33);
            drain();
        end
    endtask

    task automatic test_div();
        send(0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33); drain();
        send(0, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33); drain();
        send(0, 3'b101, 32'd100, 32'd7, 32'd14, 33); drain();
        send(0, 3'b111, 32'd100, 32'd7, 32'd2, 33); drain();
    endtask

    task automatic test_special();
        send(0, 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1); drain();
        send(0, 3'b111, 32'd5, 32'd0, 32'd5, 1); drain();
        send(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1); drain();
        send(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1); drain();
    endtask

    task automatic test_kill();
        logic [31:0] prev;
        int seen = 0;
        prev = last;
        send(0, 3'b101, 32'd1000, 32'd3, 32'd333, 33);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        void'(q.pop_back());
        last = prev;
        n_tests += 3;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL kill_ready got %b expected 1", ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b expected 0", busy); end
        if (result !== prev) begin n_fail++; $display("FAIL kill_result got %h expected %h", result, prev); end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) seen++; end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL kill_no_done got %0d expected 0", seen); end
        send(0, 3'b101, 32'd9, 32'd3, 32'd3, 33);
        drain();
        @(negedge clk);
        valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; kill = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_idle_accept got busy=%b expected 0", busy); end
        @(negedge clk);
        funct3 = 3'b100; a = 32'd5; b = 32'd0; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; kill = 1'b1;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL kill_done_gate got %b expected 0", done); end
        @(posedge clk); #1;
        kill = 1'b0;
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL kill_done_ready got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        send(0, 3'b101, 32'd77, 32'd5, 32'd15, 33);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        n_tests += 4;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b expected 1", ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b expected 0", done); end
        if (result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result got %h expected 0", result); end
        @(negedge clk) rst_n = 1'b1;
        last = '0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) seen++; end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d expected 0", seen); end
    endtask

    task automatic test_input_hold();
        send(0, 3'b101, 32'd100, 32'd7, 32'd14, 33);
        funct3 = 3'b000; a = 32'hDEADBEEF; b = 32'h0;
        repeat (10) @(negedge clk);
        a = 32'h1; b = 32'h1;
        drain();
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, prev_acc = 0;
        @(negedge clk);
        funct3 = 3'b000; a = 32'd3; b = 32'd5; valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (ready) begin
                q.push_back('{32'd15, cyc + 1, 33});
                if (n_acc > 0) begin
                    n_tests++;
                    if (cyc + 1 - prev_acc !== 34) begin n_fail++; $display("FAIL b2b_spacing got %0d expected 34", cyc + 1 - prev_acc); end
                end
                prev_acc = cyc + 1;
                n_acc++;
            end
            if (i == 69) valid = 1'b0;
            @(negedge clk);
        end
        valid = 1'b0;
        n_tests++;
        if (n_acc != 3) begin n_fail++; $display("FAIL b2b_accepts got %0d expected 3", n_acc); end
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mul_latency();
        test_mulh();
        test_div();
        test_special();
        test_kill();
        test_reset_mid();
        test_input_hold();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
